range_frame_sequencer: RTL and testbench
========================================

Name: range_frame_sequencer

Overview:
Upstream framing stage for the range (max − min) tracker.
- Buffers raw samples arriving over a valid/ready handshake in a small FIFO.
- On a start request, emits exactly frame_len samples on out_data, with out_go on the first sample and out_finish on the last.
- Guarantees the tracker never sees go and finish together, never sees finish without a preceding go, and never sees a fresh go mid-frame.

Parameters:
- DATA_W, 10, sample width; matches the tracker data input.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- LEN_W, 4, width of frame_len.

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  DATA_W  raw sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  FIFO can accept; equals !full.
- start  in  1  request a frame; sampled only in IDLE.
- frame_len  in  LEN_W  samples per frame, including first and last; sampled with start.
- out_data  out  DATA_W  sample to tracker.
- out_go  out  1  one-cycle pulse marking the first sample of a frame.
- out_finish  out  1  one-cycle pulse marking the last sample of a frame.
- busy  out  1  high in ARM and RUN.
- len_error  out  1  one-cycle pulse when start is rejected because frame_len < 2.

Behaviour:
- Reset (async, reset_n=0):
  - FIFO emptied; state IDLE.
  - out_data=0, out_go=0, out_finish=0, busy=0, len_error=0.
  - in_ready=1 once reset_n is released.
- Push: when in_valid && in_ready, in_data is written at the tail. No push while full; the sample is held off by the handshake, not dropped.
- Pop:
  - Only in ARM/RUN, and only if the FIFO is not empty.
  - No bypass: a sample pushed in cycle t is poppable from t+1.
  - Push and pop in the same cycle are allowed when neither full nor empty; occupancy is unchanged.
- FSM:
  - IDLE: on start with frame_len ≥ 2, load cnt=frame_len and go to ARM.
  - IDLE: on start with frame_len < 2, pulse len_error in the next cycle and stay in IDLE.
  - IDLE: start in any other state is ignored.
  - ARM: wait for a non-empty FIFO. The first pop registers out_go=1 with out_data=sample; then cnt−1 and go to RUN.
  - RUN: each pop decrements cnt and registers out_data=sample.
  - RUN: the pop with cnt==1 also registers out_finish=1 and returns to IDLE.
- Latency: out_data, out_go and out_finish are registered, appearing one cycle after the pop.
- Stall (FIFO empty in RUN):
  - out_go and out_finish are low.
  - out_data holds the last emitted value; the repeat is harmless to the min/max.
- out_data also holds its last value in IDLE.
- Invariants:
  - out_go and out_finish are never high in the same cycle.
  - Exactly one out_go and one out_finish per frame, with out_finish strictly after out_go.
  - Pops per frame equal frame_len exactly.
- Back-to-back frames: start is accepted in the first IDLE cycle (the cycle out_finish is visible). Earliest next out_go is 2 cycles after out_finish.
- frame_len is sampled only with start; changes during a frame have no effect.
- Reset mid-frame:
  - Immediate clear of all state, including buffered samples.
  - The tracker shares the same reset domain.
- Samples buffered while IDLE remain queued for the next frame.

Decomposition:
- Package range_pkg:
  - DATA_W default constant.
  - State enum {IDLE, ARM, RUN}.
  - Typedef for the sample word.
- Sub-module sample_fifo:
  - Parameterised by DATA_W and DEPTH.
  - Pointer plus count, with full/empty flags.
  - Push/pop strobes; same clock and reset.
- The top level holds the FSM, frame counter and output registers.

Test Plan:
1. Push 5, 9, 3; start with frame_len=3 → out_data 5 (out_go), 9, 3 (out_finish) on consecutive cycles; tracker output = 6; busy drops the cycle out_finish is visible.
2. start with frame_len=1 → len_error high one cycle; no out_go; busy stays 0; FIFO contents untouched.
3. frame_len=4; push 2, 7, wait 3 cycles, push 1, 8 → out_go with 2; out_data holds 7 with go/finish low during the stall; out_finish with 8; exactly 4 pops; tracker output = 7.
4. DEPTH=4, IDLE; hold in_valid for 6 samples 10..15 → in_ready low after 4 accepts. Then start with frame_len=6 → emits 10, 11, 12, 13, then 14, 15 after the handshake resumes; out_finish with 15.
5. Assert reset_n mid-RUN after 2 of 5 samples → outputs and busy are 0 in the same cycle (async); FIFO empty and in_ready=1 after release; the next frame starts cleanly.
6. start pulsed during RUN is ignored; back-to-back frames of len 2 (4,6) and len 3 (1,1,1) → go/finish pairs correct; no overlap; second out_go exactly 2 cycles after the first out_finish.

Source files
------------

// File: rtl/range_pkg.sv
// Shared types and defaults for the range framing path: the sample word and
// the framing FSM states.
package range_pkg;

    localparam int SAMPLE_W = 10;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN
    } state_t;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO using pointers plus an occupancy count. There is no
// bypass path, so a word written this cycle can be read from the next cycle.
module sample_fifo #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; clearing the pointers and count is enough to empty the FIFO.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/range_frame_sequencer.sv
// Frames buffered samples for the range tracker: on start, emits exactly
// frame_len samples with a go pulse on the first and a finish pulse on the last.
module range_frame_sequencer
    import range_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int DEPTH  = 4,
    parameter int LEN_W  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    output logic [DATA_W-1:0] out_data,
    output logic              out_go,
    output logic              out_finish,
    output logic              busy,
    output logic              len_error
);

    state_t            state, next_state;
    logic [LEN_W-1:0]  cnt, cnt_next;
    logic [DATA_W-1:0] data_next;
    logic              go_next, finish_next, len_error_next;
    logic              pop;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_full;
    logic              fifo_empty;

    sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign in_ready = !fifo_full;
    assign busy     = (state != IDLE);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        next_state     = state;
        cnt_next       = cnt;
        pop            = 1'b0;
        data_next      = out_data;
        go_next        = 1'b0;
        finish_next    = 1'b0;
        len_error_next = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (frame_len >= LEN_W'(2)) begin
                        cnt_next   = frame_len;
                        next_state = ARM;
                    end else begin
                        len_error_next = 1'b1;
                    end
                end
            end
            ARM: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    data_next  = fifo_data;
                    go_next    = 1'b1;
                    cnt_next   = cnt - LEN_W'(1);
                    next_state = RUN;
                end
            end
            RUN: begin
                // A stall leaves out_data holding its last value, which cannot move min/max.
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    data_next = fifo_data;
                    cnt_next  = cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) begin
                        finish_next = 1'b1;
                        next_state  = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            out_data   <= '0;
            out_go     <= 1'b0;
            out_finish <= 1'b0;
            len_error  <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            out_data   <= data_next;
            out_go     <= go_next;
            out_finish <= finish_next;
            len_error  <= len_error_next;
        end
    end

endmodule

// File: tb/tb_range_frame_sequencer.sv
// Bench for range_frame_sequencer: directed steps plus random traffic, checked
// every cycle against a queue-based model of the framing rules.
module tb_range_frame_sequencer;

    localparam int DW    = 10;
    localparam int DEPTH = 4;
    localparam int LW    = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          start = 1'b0;
    logic [LW-1:0] frame_len = '0;
    logic [DW-1:0] out_data;
    logic          out_go;
    logic          out_finish;
    logic          busy;
    logic          len_error;

    range_frame_sequencer #(.DATA_W(DW), .DEPTH(DEPTH), .LEN_W(LW)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .start      (start),
        .frame_len  (frame_len),
        .out_data   (out_data),
        .out_go     (out_go),
        .out_finish (out_finish),
        .busy       (busy),
        .len_error  (len_error)
    );

    always #5 clock = ~clock;

    // reference model: buffered samples, samples still owed to the current frame
    int            q[$];
    int            src_q[$];
    bit            src_en = 1'b1;
    int            rem = 0;
    bit            first = 1'b0;
    logic [DW-1:0] exp_data = '0;
    bit            exp_go = 1'b0, exp_fin = 1'b0, exp_lerr = 1'b0;

    // frame observations taken from the DUT outputs
    int cyc = 0;
    int n_cmp = 0, n_err = 0;
    bit in_frame = 1'b0;
    int go_data = -1, fin_data = -1, fmin = 0, fmax = 0, last_range = -1;
    int last_go_cyc = 0, last_fin_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic drive_inputs();
        in_valid = src_en && (src_q.size() > 0);
        in_data  = (src_q.size() > 0) ? DW'(src_q[0]) : '0;
    endtask

    task automatic push_src(input int v);
        src_q.push_back(v);
        drive_inputs();
    endtask

    task automatic cycle();
        bit was_idle;
        int sz0;
        int d;
        @(posedge clock);
        if (!reset_n) begin
            q.delete();
            rem = 0; first = 1'b0; exp_data = '0;
            exp_go = 1'b0; exp_fin = 1'b0; exp_lerr = 1'b0;
        end else begin
            was_idle = (rem == 0);
            sz0      = q.size();
            exp_go = 1'b0; exp_fin = 1'b0; exp_lerr = 1'b0;
            if (!was_idle && sz0 > 0) begin
                d = q.pop_front();
                exp_data = DW'(d);
                exp_go   = first;
                first    = 1'b0;
                rem--;
                exp_fin  = (rem == 0);
            end else if (was_idle && start) begin
                if (int'(frame_len) >= 2) begin
                    rem   = int'(frame_len);
                    first = 1'b1;
                end else begin
                    exp_lerr = 1'b1;
                end
            end
            if (in_valid && sz0 < DEPTH) q.push_back(src_q.pop_front());
        end
        cyc++;
        @(negedge clock);
        chk("out_data",   32'(out_data),   32'(exp_data));
        chk("out_go",     32'(out_go),     32'(exp_go));
        chk("out_finish", 32'(out_finish), 32'(exp_fin));
        chk("len_error",  32'(len_error),  32'(exp_lerr));
        chk("busy",       32'(busy),       32'(rem > 0));
        chk("in_ready",   32'(in_ready),   32'(q.size() < DEPTH));
        chk("go_fin_excl", 32'(out_go && out_finish), 32'(0));
        if (!reset_n) in_frame = 1'b0;
        if (out_go) begin
            go_data = int'(out_data); fmin = int'(out_data); fmax = int'(out_data);
            in_frame = 1'b1; last_go_cyc = cyc;
        end else if (in_frame) begin
            if (int'(out_data) < fmin) fmin = int'(out_data);
            if (int'(out_data) > fmax) fmax = int'(out_data);
        end
        if (out_finish) begin
            fin_data = int'(out_data); last_range = fmax - fmin;
            in_frame = 1'b0; last_fin_cyc = cyc;
        end
        drive_inputs();
    endtask

    task automatic kick(input int len);
        start = 1'b1;
        frame_len = LW'(len);
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_finish(input string tag, input int limit);
        int n = 0;
        while (!out_finish && n < limit) begin
            cycle();
            n++;
        end
        chk({tag, "_finish_seen"}, 32'(out_finish), 32'(1));
    endtask

    task automatic wait_go(input string tag, input int limit);
        int n = 0;
        while (!out_go && n < limit) begin
            cycle();
            n++;
        end
        chk({tag, "_go_seen"}, 32'(out_go), 32'(1));
    endtask

    initial begin
        // reset state
        reset_n = 1'b0;
        cycle();
        cycle();
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_busy",     32'(busy),     32'(0));
        reset_n = 1'b1;
        cycle();
        chk("rst_in_ready", 32'(in_ready), 32'(1));

        // 1: basic frame of 3
        push_src(5); push_src(9); push_src(3);
        repeat (3) cycle();
        kick(3);
        wait_finish("t1", 20);
        chk("t1_go_data",  32'(go_data),    32'(5));
        chk("t1_fin_data", 32'(fin_data),   32'(3));
        chk("t1_range",    32'(last_range), 32'(6));
        chk("t1_busy_low", 32'(busy),       32'(0));
        chk("t1_span",     32'(last_fin_cyc - last_go_cyc), 32'(2));

        // 2: frame_len below 2 is rejected
        kick(1);
        chk("t2_len_error", 32'(len_error), 32'(1));
        chk("t2_busy",      32'(busy),      32'(0));
        cycle();
        chk("t2_len_error_drop", 32'(len_error), 32'(0));
        chk("t2_no_go",          32'(out_go),    32'(0));

        // 3: stall in RUN
        push_src(2); push_src(7);
        kick(4);
        repeat (3) cycle();
        chk("t3_stall_data", 32'(out_data), 32'(7));
        chk("t3_stall_go",   32'(out_go),   32'(0));
        chk("t3_stall_busy", 32'(busy),     32'(1));
        push_src(1); push_src(8);
        wait_finish("t3", 20);
        chk("t3_go_data",  32'(go_data),    32'(2));
        chk("t3_fin_data", 32'(fin_data),   32'(8));
        chk("t3_range",    32'(last_range), 32'(7));

        // 4: back-pressure when full
        for (int v = 10; v <= 15; v++) push_src(v);
        repeat (4) cycle();
        chk("t4_full", 32'(in_ready), 32'(0));
        repeat (2) cycle();
        chk("t4_still_full", 32'(in_ready), 32'(0));
        kick(6);
        wait_finish("t4", 40);
        chk("t4_go_data",  32'(go_data),    32'(10));
        chk("t4_fin_data", 32'(fin_data),   32'(15));
        chk("t4_range",    32'(last_range), 32'(5));

        // 5: reset in the middle of a frame
        for (int v = 20; v <= 24; v++) push_src(v);
        kick(5);
        wait_go("t5", 20);
        cycle();
        #2 reset_n = 1'b0;
        #1;
        chk("t5_async_data",   32'(out_data),   32'(0));
        chk("t5_async_go",     32'(out_go),     32'(0));
        chk("t5_async_finish", 32'(out_finish), 32'(0));
        chk("t5_async_busy",   32'(busy),       32'(0));
        src_q.delete();
        drive_inputs();
        cycle();
        cycle();
        reset_n = 1'b1;
        cycle();
        chk("t5_ready_after", 32'(in_ready), 32'(1));
        push_src(30); push_src(40); push_src(35);
        kick(3);
        wait_finish("t5", 20);
        chk("t5_go_data",  32'(go_data),    32'(30));
        chk("t5_fin_data", 32'(fin_data),   32'(35));
        chk("t5_range",    32'(last_range), 32'(10));

        // 6: ignored start and back-to-back frames
        push_src(4); push_src(6); push_src(1); push_src(1); push_src(1);
        kick(2);
        cycle();
        chk("t6_go1", 32'(out_go), 32'(1));
        kick(7);
        chk("t6_fin1",      32'(out_finish), 32'(1));
        chk("t6_fin1_data", 32'(out_data),   32'(6));
        kick(3);
        wait_go("t6b", 10);
        chk("t6_gap", 32'(last_go_cyc - last_fin_cyc), 32'(2));
        wait_finish("t6b", 20);
        chk("t6_fin2_data", 32'(fin_data),   32'(1));
        chk("t6_range2",    32'(last_range), 32'(0));

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            src_en = ($urandom_range(0, 3) != 0);
            if (src_q.size() < 3 && $urandom_range(0, 1) == 1) src_q.push_back(int'($urandom_range(0, 1023)));
            drive_inputs();
            start = ($urandom_range(0, 7) == 0);
            frame_len = LW'($urandom_range(0, 7));
            cycle();
        end
        start = 1'b0;
        src_en = 1'b1;
        for (int i = 0; i < 100 && rem > 0; i++) begin
            if (src_q.size() < 2) src_q.push_back(int'($urandom_range(0, 1023)));
            drive_inputs();
            cycle();
        end
        chk("drain_idle", 32'(busy), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
